// File: rtl/rr_mem_port_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// rr_mem_port_arbiter_pkg
//   Shared definitions for the round-robin memory port arbiter:
//   - arb_state_e : sequencer state encoding (ARB_IDLE, ARB_BUSY, ARB_RELEASE)
//   - clog2       : constant function used to size the burst/wait counters
// -----------------------------------------------------------------------------
package rr_mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

  // Ceiling log2; callers always pass values >= 2 so the result is >= 1.
  function automatic int clog2(input int value);
    int result;
    int remaining;
    result    = 0;
    remaining = value - 1;
    while (remaining > 0) begin
      result    = result + 1;
      remaining = remaining >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/rr_mem_port_arbiter_if.sv
// -----------------------------------------------------------------------------
// rr_mem_port_arbiter_if
//   Bundles the requester-side and memory-side signals of the arbiter.
//   Requester side : Request, ReqAddress, ReqWriteEnable, ReqWriteData in;
//                    Grant, Ack, Abort, ReadData, TimeoutError out.
//   Memory side    : MemRequest, MemAddress, MemWriteEnable, MemWriteData out;
//                    MemAck, MemReadData in.
//   Packed per-requester fields: requester i at [i*W +: W].
//   Modports:
//   - slave  : the arbiter's view
//   - master : the environment (requesters + memory) view
// -----------------------------------------------------------------------------
interface rr_mem_port_arbiter_if #(
  parameter int NUM_REQ = 3,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 32
);

  // Requester side
  logic [NUM_REQ-1:0]        Request;
  logic [NUM_REQ*ADDR_W-1:0] ReqAddress;
  logic [NUM_REQ-1:0]        ReqWriteEnable;
  logic [NUM_REQ*DATA_W-1:0] ReqWriteData;
  logic [NUM_REQ-1:0]        Grant;
  logic [NUM_REQ-1:0]        Ack;
  logic [NUM_REQ-1:0]        Abort;
  logic [DATA_W-1:0]         ReadData;
  logic                      TimeoutError;

  // Memory side
  logic                      MemRequest;
  logic [ADDR_W-1:0]         MemAddress;
  logic                      MemWriteEnable;
  logic [DATA_W-1:0]         MemWriteData;
  logic                      MemAck;
  logic [DATA_W-1:0]         MemReadData;

  modport slave (
    input  Request, ReqAddress, ReqWriteEnable, ReqWriteData,
    input  MemAck, MemReadData,
    output Grant, Ack, Abort, ReadData, TimeoutError,
    output MemRequest, MemAddress, MemWriteEnable, MemWriteData
  );

  modport master (
    output Request, ReqAddress, ReqWriteEnable, ReqWriteData,
    output MemAck, MemReadData,
    input  Grant, Ack, Abort, ReadData, TimeoutError,
    input  MemRequest, MemAddress, MemWriteEnable, MemWriteData
  );

endinterface

// File: rtl/rr_mem_port_arbiter_priority_select.sv
// -----------------------------------------------------------------------------
// rr_priority_select
//   Combinational round-robin pick: returns the first set request bit at or
//   circularly after the one-hot priority pointer.
//   Ports:
//   - request [NUM_REQ] : raw request vector
//   - ptr     [NUM_REQ] : one-hot priority pointer
//   - winner  [NUM_REQ] : one-hot winner, 0 when request == 0
// -----------------------------------------------------------------------------
module rr_priority_select #(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] request,
  input  logic [NUM_REQ-1:0] ptr,
  output logic [NUM_REQ-1:0] winner
);

  logic [2*NUM_REQ-1:0] double_req;
  logic [2*NUM_REQ-1:0] double_base;
  logic [2*NUM_REQ-1:0] double_win;

  // Duplicating the request vector turns the circular search into a linear
  // one: subtracting the pointer borrows through the clear bits below the
  // first set bit at/above ptr, so req & ~(req - base) isolates that bit.
  // A hit in the upper copy means the search wrapped past bit NUM_REQ-1.
  assign double_req  = {request, request};
  assign double_base = {{NUM_REQ{1'b0}}, ptr};
  assign double_win  = double_req & ~(double_req - double_base);

  assign winner = double_win[NUM_REQ-1:0] | double_win[2*NUM_REQ-1:NUM_REQ];

endmodule

// File: rtl/rr_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// rr_mem_port_arbiter
//   Shares a single memory port among NUM_REQ requesters. A walking-one
//   pointer picks the next requester round-robin; the granted requester may
//   issue up to MAX_BURST back-to-back transactions before the pointer
//   rotates past it. A watchdog aborts a transaction after TIMEOUT cycles
//   without MemAck and raises a sticky TimeoutError.
//   Ports:
//   - Clock : all state on posedge
//   - Reset : asynchronous, active-high
//   - bus   : rr_mem_port_arbiter_if.slave
//     Grant        registered one-hot grant, 0 when idle
//     Ack          Grant & MemAck while BUSY
//     Abort        one-cycle pulse to the granted requester on timeout
//     ReadData     MemReadData passthrough, valid with Ack
//     MemRequest   registered memory request
//     MemAddress / MemWriteEnable / MemWriteData
//                  muxed from the granted requester, 0 when Grant == 0
//     TimeoutError sticky until Reset
// -----------------------------------------------------------------------------
module rr_mem_port_arbiter
  import rr_mem_port_arbiter_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 32,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 255
) (
  input  logic                  Clock,
  input  logic                  Reset,
  rr_mem_port_arbiter_if.slave  bus
);

  localparam int WAIT_W  = clog2(TIMEOUT + 1);
  localparam int BURST_W = clog2(MAX_BURST + 1);

  localparam logic [WAIT_W-1:0]  WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [BURST_W-1:0] BURST_MAX = BURST_W'(MAX_BURST);
  localparam logic [NUM_REQ-1:0] PTR_INIT  = NUM_REQ'(1);

  arb_state_e           state_q, state_d;
  logic [NUM_REQ-1:0]   grant_q, grant_d;
  logic [NUM_REQ-1:0]   ptr_q, ptr_d;
  logic [NUM_REQ-1:0]   abort_q, abort_d;
  logic                 mem_request_q, mem_request_d;
  logic                 timeout_error_q, timeout_error_d;
  logic [BURST_W-1:0]   burst_cnt_q, burst_cnt_d;
  logic [WAIT_W-1:0]    wait_cnt_q, wait_cnt_d;

  logic [NUM_REQ-1:0]   winner;
  logic [NUM_REQ-1:0]   grant_rotated;
  logic                 grant_still_requests;

  logic [ADDR_W-1:0]    mem_address;
  logic                 mem_write_enable;
  logic [DATA_W-1:0]    mem_write_data;

  // ---------------------------------------------------------------------------
  // Round-robin winner for the IDLE -> BUSY transition
  // ---------------------------------------------------------------------------
  rr_priority_select #(
    .NUM_REQ (NUM_REQ)
  ) u_priority_select (
    .request (bus.Request),
    .ptr     (ptr_q),
    .winner  (winner)
  );

  // Next pointer is one past the current grant; the top bit wraps to bit 0.
  assign grant_rotated        = {grant_q[NUM_REQ-2:0], grant_q[NUM_REQ-1]};
  assign grant_still_requests = |(bus.Request & grant_q);

  // ---------------------------------------------------------------------------
  // Next-state / datapath logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    state_d         = state_q;
    grant_d         = grant_q;
    ptr_d           = ptr_q;
    abort_d         = '0;
    mem_request_d   = mem_request_q;
    timeout_error_d = timeout_error_q;
    burst_cnt_d     = burst_cnt_q;
    wait_cnt_d      = wait_cnt_q;

    unique case (state_q)
      ARB_IDLE: begin
        if (|bus.Request) begin
          state_d       = ARB_BUSY;
          grant_d       = winner;
          mem_request_d = 1'b1;
          burst_cnt_d   = BURST_W'(1);
          wait_cnt_d    = '0;
        end
      end

      ARB_BUSY: begin
        // An ack arriving on the last watchdog cycle still completes normally.
        if (bus.MemAck) begin
          mem_request_d = 1'b0;
          state_d       = ARB_RELEASE;
        end else if (wait_cnt_q == WAIT_LAST) begin
          abort_d         = grant_q;
          timeout_error_d = 1'b1;
          mem_request_d   = 1'b0;
          state_d         = ARB_RELEASE;
          // Forcing the burst count to its limit makes RELEASE rotate away
          // from a requester whose memory access just hung.
          burst_cnt_d     = BURST_MAX;
        end else begin
          wait_cnt_d = wait_cnt_q + WAIT_W'(1);
        end
      end

      ARB_RELEASE: begin
        if (grant_still_requests && (burst_cnt_q < BURST_MAX)) begin
          state_d       = ARB_BUSY;
          burst_cnt_d   = burst_cnt_q + BURST_W'(1);
          wait_cnt_d    = '0;
          mem_request_d = 1'b1;
        end else begin
          state_d     = ARB_IDLE;
          ptr_d       = grant_rotated;
          grant_d     = '0;
          burst_cnt_d = '0;
        end
      end

      default: begin
        state_d       = ARB_IDLE;
        grant_d       = '0;
        mem_request_d = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge Clock or posedge Reset) begin
    // NOTE: non-blocking assignments so every register samples the values
    // present before the edge, independent of statement order.
    if (Reset) begin
      state_q         <= ARB_IDLE;
      grant_q         <= '0;
      ptr_q           <= PTR_INIT;
      abort_q         <= '0;
      mem_request_q   <= 1'b0;
      timeout_error_q <= 1'b0;
      burst_cnt_q     <= '0;
      wait_cnt_q      <= '0;
    end else begin
      state_q         <= state_d;
      grant_q         <= grant_d;
      ptr_q           <= ptr_d;
      abort_q         <= abort_d;
      mem_request_q   <= mem_request_d;
      timeout_error_q <= timeout_error_d;
      burst_cnt_q     <= burst_cnt_d;
      wait_cnt_q      <= wait_cnt_d;
    end
  end

  // ---------------------------------------------------------------------------
  // One-hot request mux onto the memory port (all zero when nothing granted)
  // ---------------------------------------------------------------------------
  always_comb begin
    mem_address      = '0;
    mem_write_enable = 1'b0;
    mem_write_data   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant_q[i]) begin
        mem_address      = mem_address    | bus.ReqAddress[i*ADDR_W +: ADDR_W];
        mem_write_enable = mem_write_enable | bus.ReqWriteEnable[i];
        mem_write_data   = mem_write_data | bus.ReqWriteData[i*DATA_W +: DATA_W];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.Grant          = grant_q;
  assign bus.Abort          = abort_q;
  assign bus.MemRequest     = mem_request_q;
  assign bus.TimeoutError   = timeout_error_q;
  assign bus.MemAddress     = mem_address;
  assign bus.MemWriteEnable = mem_write_enable;
  assign bus.MemWriteData   = mem_write_data;
  assign bus.ReadData       = bus.MemReadData;

  // Gating by BUSY keeps a stray MemAck outside a transaction from acking.
  assign bus.Ack = (state_q == ARB_BUSY) ? (grant_q & {NUM_REQ{bus.MemAck}})
                                         : '0;

endmodule

// File: tb/tb_rr_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rr_mem_port_arbiter
//   Directed bench for rr_mem_port_arbiter with NUM_REQ=3, MAX_BURST=2,
//   TIMEOUT=8. A small memory model acks ack_delay cycles after MemRequest
//   rises (or never, when mem_auto is clear) and returns {16'hC0DE, address}.
//   Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_rr_mem_port_arbiter;

  localparam int NUM_REQ   = 3;
  localparam int ADDR_W    = 16;
  localparam int DATA_W    = 32;
  localparam int MAX_BURST = 2;
  localparam int TIMEOUT   = 8;

  localparam logic [ADDR_W-1:0] A0 = 16'h1A00;
  localparam logic [ADDR_W-1:0] A1 = 16'h2B11;
  localparam logic [ADDR_W-1:0] A2 = 16'h3C22;

  logic Clock;
  logic Reset;

  int n_checks;
  int n_fail;

  bit mem_auto;
  int ack_delay;

  logic [NUM_REQ-1:0] exp_q [$];

  rr_mem_port_arbiter_if #(
    .NUM_REQ (NUM_REQ),
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W)
  ) bus ();

  rr_mem_port_arbiter #(
    .NUM_REQ   (NUM_REQ),
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .MAX_BURST (MAX_BURST),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .Clock (Clock),
    .Reset (Reset),
    .bus   (bus)
  );

  initial begin
    Clock = 1'b0;
    forever #5 Clock = ~Clock;
  end

  // Memory model: single-cycle MemAck pulse ack_delay cycles after MemRequest.
  initial begin : mem_model
    int cnt;
    cnt             = 0;
    bus.MemAck      = 1'b0;
    bus.MemReadData = '0;
    forever begin
      @(posedge Clock);
      #1;
      if (bus.MemAck) begin
        bus.MemAck = 1'b0;
        cnt        = 0;
      end else if (bus.MemRequest && mem_auto) begin
        cnt = cnt + 1;
        if (cnt == ack_delay + 1) begin
          bus.MemAck      = 1'b1;
          bus.MemReadData = {16'hC0DE, bus.MemAddress};
          cnt             = 0;
        end
      end else begin
        cnt = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at %0t, required finish", $time);
    $fatal(1, "global timeout");
  end

  function automatic logic [ADDR_W-1:0] exp_addr(input logic [NUM_REQ-1:0] g);
    case (g)
      3'b001:  return A0;
      3'b010:  return A1;
      3'b100:  return A2;
      default: return '0;
    endcase
  endfunction

  task automatic do_reset();
    @(negedge Clock);
    Reset              = 1'b1;
    bus.Request        = '0;
    bus.ReqAddress     = {A2, A1, A0};
    bus.ReqWriteEnable = '0;
    bus.ReqWriteData   = '0;
    mem_auto           = 1'b1;
    ack_delay          = 2;
    @(negedge Clock);
    Reset = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    do_reset();
    for (int c = 0; c < 10; c++) begin
      @(negedge Clock);
      n_checks++;
      if (bus.Grant !== 3'b000 || bus.MemRequest !== 1'b0 ||
          bus.TimeoutError !== 1'b0 || bus.Abort !== 3'b000) begin
        n_fail++;
        $display("FAIL reset_idle c%0d: Grant=%b MemRequest=%b TimeoutError=%b Abort=%b, required 000/0/0/000",
                 c, bus.Grant, bus.MemRequest, bus.TimeoutError, bus.Abort);
      end
    end

    bus.Request = 3'b001;
    @(negedge Clock);
    n_checks++;
    if (bus.Grant !== 3'b001 || bus.MemRequest !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre_busy: Grant=%b MemRequest=%b, required 001/1", bus.Grant, bus.MemRequest);
    end
    #1 Reset = 1'b1;
    #1;
    n_checks++;
    if (bus.Grant !== 3'b000 || bus.MemRequest !== 1'b0 || bus.Ack !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_async_mid_busy: Grant=%b MemRequest=%b Ack=%b, required 000/0/000",
               bus.Grant, bus.MemRequest, bus.Ack);
    end
    @(negedge Clock);
    Reset       = 1'b0;
    bus.Request = '0;
    @(negedge Clock);
    n_checks++;
    if (bus.Grant !== 3'b000 || bus.MemRequest !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_after_release: Grant=%b MemRequest=%b, required 000/0", bus.Grant, bus.MemRequest);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Holds req and follows the expected ack sequence in exp_q.
  task automatic run_rotation(input string name, input logic [NUM_REQ-1:0] req);
    int got;
    int cyc;
    got = 0;
    cyc = 0;
    do_reset();
    bus.Request = req;
    @(negedge Clock);
    n_checks++;
    if (bus.Grant !== exp_q[0] || bus.MemRequest !== 1'b1) begin
      n_fail++;
      $display("FAIL %s_first_grant: Grant=%b MemRequest=%b, required %b/1", name, bus.Grant, bus.MemRequest, exp_q[0]);
    end
    while (got < exp_q.size() && cyc < 200) begin
      if (bus.MemRequest === 1'b1) begin
        n_checks++;
        if (bus.Grant !== exp_q[got] || bus.MemAddress !== exp_addr(exp_q[got])) begin
          n_fail++;
          $display("FAIL %s_busy_mux t%0d: Grant=%b MemAddress=%h, required %b/%h",
                   name, got, bus.Grant, bus.MemAddress, exp_q[got], exp_addr(exp_q[got]));
        end
      end
      if (bus.Ack !== 3'b000) begin
        n_checks++;
        if (bus.Ack !== exp_q[got] || bus.ReadData !== {16'hC0DE, exp_addr(exp_q[got])}) begin
          n_fail++;
          $display("FAIL %s_ack t%0d: Ack=%b ReadData=%h, required %b/%h",
                   name, got, bus.Ack, bus.ReadData, exp_q[got], {16'hC0DE, exp_addr(exp_q[got])});
        end
        got++;
      end
      @(negedge Clock);
      cyc++;
    end
    n_checks++;
    if (got != exp_q.size()) begin
      n_fail++;
      $display("FAIL %s_ack_count: got %0d acks in %0d cycles, required %0d", name, got, cyc, exp_q.size());
    end
    bus.Request = '0;
  endtask

  task automatic test_burst_101();
    exp_q = {3'b001, 3'b001, 3'b100, 3'b100, 3'b001, 3'b001};
    run_rotation("burst_101", 3'b101);
  endtask

  task automatic test_rr_111();
    exp_q = {3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100, 3'b001, 3'b001};
    run_rotation("rr_111", 3'b111);
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_write();
    int cyc;
    do_reset();
    bus.ReqAddress     = {A2, 16'h1234, A0};
    bus.ReqWriteData   = {32'h0, 32'hDEADBEEF, 32'h0};
    bus.ReqWriteEnable = 3'b010;
    bus.Request        = 3'b010;
    @(negedge Clock);
    n_checks++;
    if (bus.Grant !== 3'b010 || bus.MemRequest !== 1'b1 || bus.MemAddress !== 16'h1234 ||
        bus.MemWriteEnable !== 1'b1 || bus.MemWriteData !== 32'hDEADBEEF) begin
      n_fail++;
      $display("FAIL write_mux: Grant=%b MemRequest=%b MemAddress=%h MemWriteEnable=%b MemWriteData=%h, required 010/1/1234/1/deadbeef",
               bus.Grant, bus.MemRequest, bus.MemAddress, bus.MemWriteEnable, bus.MemWriteData);
    end
    cyc = 0;
    while (bus.MemAck !== 1'b1 && cyc < 20) begin
      @(negedge Clock);
      cyc++;
    end
    n_checks++;
    if (bus.Ack !== 3'b010 || cyc != 2) begin
      n_fail++;
      $display("FAIL write_ack: Ack=%b after %0d cycles, required 010 after 2", bus.Ack, cyc);
    end
    bus.Request = '0;
    @(negedge Clock);
    n_checks++;
    if (bus.Grant !== 3'b010 || bus.MemRequest !== 1'b0 || bus.Ack !== 3'b000) begin
      n_fail++;
      $display("FAIL write_release: Grant=%b MemRequest=%b Ack=%b, required 010/0/000",
               bus.Grant, bus.MemRequest, bus.Ack);
    end
    @(negedge Clock);
    n_checks++;
    if (bus.Grant !== 3'b000 || bus.MemAddress !== 16'h0 ||
        bus.MemWriteEnable !== 1'b0 || bus.MemWriteData !== 32'h0) begin
      n_fail++;
      $display("FAIL write_idle_zero: Grant=%b MemAddress=%h MemWriteEnable=%b MemWriteData=%h, required all 0",
               bus.Grant, bus.MemAddress, bus.MemWriteEnable, bus.MemWriteData);
    end
    bus.ReqWriteEnable = '0;
    bus.Request        = 3'b111;
    @(negedge Clock);
    n_checks++;
    if (bus.Grant !== 3'b100) begin
      n_fail++;
      $display("FAIL write_ptr_rotated: Grant=%b, required 100", bus.Grant);
    end
    bus.Request = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_timeout();
    int cyc;
    do_reset();
    mem_auto    = 1'b0;
    bus.Request = 3'b001;
    for (int c = 0; c < TIMEOUT; c++) begin
      @(negedge Clock);
      n_checks++;
      if (bus.Grant !== 3'b001 || bus.MemRequest !== 1'b1 || bus.Abort !== 3'b000) begin
        n_fail++;
        $display("FAIL timeout_wait c%0d: Grant=%b MemRequest=%b Abort=%b, required 001/1/000",
                 c, bus.Grant, bus.MemRequest, bus.Abort);
      end
    end
    @(negedge Clock);
    n_checks++;
    if (bus.Abort !== 3'b001 || bus.TimeoutError !== 1'b1 ||
        bus.MemRequest !== 1'b0 || bus.Grant !== 3'b001) begin
      n_fail++;
      $display("FAIL timeout_abort: Abort=%b TimeoutError=%b MemRequest=%b Grant=%b, required 001/1/0/001",
               bus.Abort, bus.TimeoutError, bus.MemRequest, bus.Grant);
    end
    bus.Request = 3'b011;
    @(negedge Clock);
    n_checks++;
    if (bus.Abort !== 3'b000 || bus.Grant !== 3'b000 || bus.TimeoutError !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_rotate: Abort=%b Grant=%b TimeoutError=%b, required 000/000/1",
               bus.Abort, bus.Grant, bus.TimeoutError);
    end
    mem_auto = 1'b1;
    @(negedge Clock);
    n_checks++;
    if (bus.Grant !== 3'b010 || bus.MemRequest !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_next_grant: Grant=%b MemRequest=%b, required 010/1", bus.Grant, bus.MemRequest);
    end
    cyc = 0;
    while (bus.MemAck !== 1'b1 && cyc < 20) begin
      @(negedge Clock);
      cyc++;
    end
    n_checks++;
    if (bus.Ack !== 3'b010 || bus.TimeoutError !== 1'b1) begin
      n_fail++;
      $display("FAIL timeout_sticky: Ack=%b TimeoutError=%b, required 010/1", bus.Ack, bus.TimeoutError);
    end
    bus.Request = '0;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_ack_at_timeout();
    do_reset();
    ack_delay   = TIMEOUT - 1;
    bus.Request = 3'b001;
    for (int c = 0; c < TIMEOUT - 1; c++) begin
      @(negedge Clock);
      n_checks++;
      if (bus.Ack !== 3'b000 || bus.Abort !== 3'b000 || bus.MemRequest !== 1'b1) begin
        n_fail++;
        $display("FAIL edge_wait c%0d: Ack=%b Abort=%b MemRequest=%b, required 000/000/1",
                 c, bus.Ack, bus.Abort, bus.MemRequest);
      end
    end
    @(negedge Clock);
    n_checks++;
    if (bus.Ack !== 3'b001) begin
      n_fail++;
      $display("FAIL edge_ack: Ack=%b, required 001", bus.Ack);
    end
    bus.Request = '0;
    @(negedge Clock);
    n_checks++;
    if (bus.Abort !== 3'b000 || bus.TimeoutError !== 1'b0 ||
        bus.MemRequest !== 1'b0 || bus.Grant !== 3'b001) begin
      n_fail++;
      $display("FAIL edge_no_abort: Abort=%b TimeoutError=%b MemRequest=%b Grant=%b, required 000/0/0/001",
               bus.Abort, bus.TimeoutError, bus.MemRequest, bus.Grant);
    end
    @(negedge Clock);
    n_checks++;
    if (bus.Abort !== 3'b000 || bus.TimeoutError !== 1'b0 || bus.Grant !== 3'b000) begin
      n_fail++;
      $display("FAIL edge_idle: Abort=%b TimeoutError=%b Grant=%b, required 000/0/000",
               bus.Abort, bus.TimeoutError, bus.Grant);
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    n_checks           = 0;
    n_fail             = 0;
    mem_auto           = 1'b1;
    ack_delay          = 2;
    Reset              = 1'b1;
    bus.Request        = '0;
    bus.ReqAddress     = {A2, A1, A0};
    bus.ReqWriteEnable = '0;
    bus.ReqWriteData   = '0;

    test_reset();
    test_burst_101();
    test_rr_111();
    test_single_write();
    test_timeout();
    test_ack_at_timeout();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
